// File: rtl/div_iter_param_pkg.sv
// Shared types and constants for the iterative restoring divider.
// State encoding, divide-by-zero result pattern and signed-MIN helper.
package div_iter_param_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  // Divide-by-zero quotient is all ones; slice to the operand width at use.
  localparam logic [63:0] DIV0_QUOT = '1;
  localparam logic        DIV0_FLAG = 1'b1;

  function automatic logic [63:0] div_signed_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor at WIDTH+1 bits, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {part_rem, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      next_rem = diff[WIDTH-1:0];
      q_bit    = 1'b1;
    end else begin
      next_rem = shifted[WIDTH-1:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/div_iter_param.sv
// Parametrised iterative restoring divider, STEPS quotient bits per cycle.
// Handshake: start_i is held until ready_o, then dropped to release the result.
module div_iter_param
  import div_iter_param_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signed_div_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             start_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div0_o,
  output logic             ovf_o
);

  localparam int ITER = WIDTH / STEPS;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [63:0]      MIN64  = div_signed_min(WIDTH);
  localparam logic [WIDTH-1:0] MIN    = MIN64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIV0_Q = DIV0_QUOT[WIDTH-1:0];

  div_state_e state, state_n;

  logic             sgn_q, neg1_q, neg2_q, ovf_pend_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, prem_q;
  logic [CW-1:0]    cnt_q;

  logic             neg1, neg2, op2_zero, ovf_case, last_iter, accept;
  logic [WIDTH-1:0] mag1, mag2, dvd_n;
  logic [STEPS-1:0] q_vec;
  logic [WIDTH-1:0] rem_chain [STEPS+1];

  assign neg1      = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2      = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1      = neg1 ? -opdata1_i : opdata1_i;
  assign mag2      = neg2 ? -opdata2_i : opdata2_i;
  assign op2_zero  = (opdata2_i == '0);
  assign ovf_case  = signed_div_i & (opdata1_i == MIN) & (&opdata2_i);
  assign last_iter = (cnt_q == CW'(ITER - 1));
  assign accept    = start_i & ~annul_i;
  assign busy_o    = (state == DIV_BUSY) || (state == DIV_FIX);

  // Chain of STEPS restoring steps; the dividend register shifts out its
  // MSBs and collects the quotient bits at the LSB end.
  assign rem_chain[0] = prem_q;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .part_rem (rem_chain[i]),
      .dvd_bit  (dvd_q[WIDTH-1-i]),
      .divisor  (dvs_q),
      .next_rem (rem_chain[i+1]),
      .q_bit    (q_vec[STEPS-1-i])
    );
  end
  assign dvd_n = {dvd_q[WIDTH-STEPS-1:0], q_vec};

  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: if (accept) state_n = op2_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: begin
        if (annul_i)        state_n = DIV_IDLE;
        else if (last_iter) state_n = DIV_FIX;
      end
      DIV_FIX:  state_n = annul_i ? DIV_IDLE : DIV_DONE;
      DIV_DONE: if (!start_i) state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      sgn_q      <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      cnt_q      <= '0;
      ready_o    <= 1'b0;
      quot_o     <= '0;
      rem_o      <= '0;
      div0_o     <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        DIV_IDLE: if (accept) begin
          sgn_q      <= signed_div_i;
          neg1_q     <= neg1;
          neg2_q     <= neg2;
          ovf_pend_q <= ovf_case;
          dvd_q      <= mag1;
          dvs_q      <= mag2;
          prem_q     <= '0;
          cnt_q      <= '0;
          if (op2_zero) begin
            quot_o  <= DIV0_Q;
            rem_o   <= opdata1_i;
            div0_o  <= DIV0_FLAG;
            ready_o <= 1'b1;
          end
        end
        DIV_BUSY: if (!annul_i) begin
          dvd_q  <= dvd_n;
          prem_q <= rem_chain[STEPS];
          cnt_q  <= cnt_q + CW'(1);
        end
        // MIN / -1 needs no special path: the magnitude quotient truncates to MIN.
        DIV_FIX: if (!annul_i) begin
          quot_o  <= (sgn_q & (neg1_q ^ neg2_q)) ? -dvd_q : dvd_q;
          rem_o   <= (sgn_q & neg1_q) ? -prem_q : prem_q;
          ovf_o   <= ovf_pend_q;
          ready_o <= 1'b1;
        end
        DIV_DONE: if (!start_i) begin
          ready_o <= 1'b0;
          quot_o  <= '0;
          rem_o   <= '0;
          div0_o  <= 1'b0;
          ovf_o   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_iter_param.md
Name: div_iter_param

Overview:
- Parametrised iterative restoring integer divider. Successor to the fixed 32-bit, 1-bit-per-cycle divider in the EX stage.
- Adds configurable operand width and configurable quotient bits retired per cycle.
- Latches operands at start, so callers may change inputs mid-operation.
- Returns separate quotient and remainder, with explicit divide-by-zero and signed-overflow flags.
- Sits beside the ALU and is stalled on by the pipeline through busy_o / ready_o.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; even, 8..64.
- STEPS, 1, quotient bits resolved per cycle; must divide WIDTH; 1, 2 or 4.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; must stay high until ready_o seen, then dropped to release result
- annul_i  in  1  cancel in-flight divide (pipeline flush)
- busy_o  out  1  high in BUSY and FIX
- ready_o  out  1  result valid
- quot_o  out  WIDTH  quotient
- rem_o  out  WIDTH  remainder
- div0_o  out  1  divisor was zero; valid with ready_o
- ovf_o  out  1  signed MIN / -1; valid with ready_o

Behaviour:
- Reset: state=IDLE; busy_o=0, ready_o=0, quot_o=0, rem_o=0, div0_o=0, ovf_o=0. Reset in any state aborts the operation immediately; no ready_o follows.
- States: IDLE, BUSY, FIX, DONE.
- IDLE, start_i=1 and annul_i=0 at edge E0:
  - Latch signed_div_i, both operand signs, and the magnitudes |op1| and |op2| as unsigned WIDTH-bit values. |MIN| = 2^(WIDTH-1).
  - Clear the partial remainder; cnt=0.
  - If opdata2_i==0: go to DONE at E0, with quot_o = all ones, rem_o = opdata1_i, div0_o=1.
  - Otherwise go to BUSY.
- BUSY: each edge performs STEPS chained restoring steps:
  - Shift the remainder left, bringing in the next dividend bit (MSB first).
  - Trial-subtract the divisor magnitude at WIDTH+1 bits.
  - On a non-negative result, keep the difference and set the quotient bit to 1; otherwise keep the remainder and set the bit to 0.
  - cnt += 1. After ITER = WIDTH/STEPS edges, go to FIX.
- FIX (one edge):
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend was negative (remainder takes the dividend's sign).
  - ovf_o=1 if signed and dividend=MIN and divisor=-1. In that case quot_o=MIN and rem_o=0, the natural result of truncating the magnitude quotient.
  - Load quot_o/rem_o/flags; ready_o=1; go to DONE.
- Latency: ready_o is first high after edge E0+ITER+1 (WIDTH=32, STEPS=1: 33 edges; STEPS=4: 9 edges). Divide-by-zero: high after E0.
- DONE:
  - Hold all outputs stable while start_i=1.
  - On an edge with start_i=0: ready_o=0, quot_o/rem_o/flags cleared to 0, go to IDLE.
  - A new start cannot be accepted earlier than the edge after returning to IDLE.
- annul_i=1 in BUSY or FIX: go to IDLE at the next edge. ready_o stays 0, outputs stay 0. annul_i is ignored in DONE.
- start_i high while busy: ignored, no restart. Input changes after E0 have no effect.
- Unsigned mode: opdata1_i/opdata2_i MSBs are data bits, never signs.

Decomposition:
- Shared package:
  - state encoding (DIV_IDLE/BUSY/FIX/DONE);
  - divide-by-zero result constants;
  - a signed-MIN helper function of WIDTH.
- Sub-module div_step: a combinational single restoring step, parametrised by WIDTH. Inputs are the partial remainder, the next dividend bit and the divisor. Outputs are the new remainder and the quotient bit. It is instantiated STEPS times in a generate chain inside div_iter_param.

Test Plan:
- WIDTH=32, STEPS=1, unsigned 100/7 -> quot_o=14, rem_o=2, ready_o after exactly 33 edges, div0_o=ovf_o=0; drop start_i -> outputs 0 the next edge.
- Signed -7/2 -> quot_o=0xFFFFFFFD (-3), rem_o=0xFFFFFFFF (-1). Signed 7/-2 -> -3, 1. Unsigned 0xFFFFFFF9/2 -> 0x7FFFFFFC, 1.
- Signed 0x80000000 / 0xFFFFFFFF -> quot_o=0x80000000, rem_o=0, ovf_o=1. The same operands unsigned -> quot_o=0, rem_o=0x80000000, ovf_o=0.
- Divisor 0, dividend 0x1234 -> ready_o after 1 edge, div0_o=1, quot_o=0xFFFFFFFF, rem_o=0x1234.
- annul_i pulsed at BUSY cycle 10 -> no ready_o, busy_o=0 next edge. A new start 1000/10 then yields 100 rem 0 with normal latency. Likewise rst mid-BUSY returns all outputs to 0.
- WIDTH=32, STEPS=4 and WIDTH=16, STEPS=2: 1000 random signed/unsigned pairs checked against the reference model. Latency 9 / 9 edges. Operand inputs randomised during BUSY have no effect.
